// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache backing memory: FSM encoding, default geometry and
// address-width helpers used by both the memory model and the cache controller.
package cache_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRead,
    StWrite,
    StDoneRd,
    StDoneWr
  } mem_state_e;

  localparam int unsigned DefBlockSize = 2;
  localparam int unsigned DefLineSize  = 32;
  localparam int unsigned DefDepthLog2 = 11;
  localparam int unsigned DefLatency   = 2;
  localparam int unsigned DefWords     = 2 ** DefBlockSize;
  localparam int unsigned DefBlockBits = DefWords * DefLineSize;

  function automatic int unsigned block_addr_width(int unsigned depth_log2,
                                                   int unsigned block_size);
    return depth_log2 - block_size;
  endfunction

  function automatic int unsigned words_per_block(int unsigned block_size);
    return 1 << block_size;
  endfunction

endpackage

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer for burst_memory: accepts one request at a time, waits the access latency,
// then steps a beat index across the block and pulses the matching done flag.
module mem_burst_ctrl
  import cache_mem_pkg::*;
#(
  parameter int unsigned c_block_size   = 2,
  parameter int unsigned access_latency = 2
) (
  input  logic                    m_clk_i,
  input  logic                    m_reset_i,
  input  logic                    m_read_i,
  input  logic                    m_wr_i,
  output logic                    m_busywait_o,
  output logic                    m_read_done_o,
  output logic                    m_write_done_o,
  output logic                    accept_o,
  output logic [c_block_size-1:0] beat_o,
  output logic                    wr_stb_o,
  output logic                    cap_stb_o,
  output logic                    last_beat_o
);

  localparam int unsigned LatW = (access_latency > 1) ? $clog2(access_latency) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'((access_latency == 0) ? 0 : access_latency - 1);
  localparam logic [c_block_size-1:0] BeatLast = '1;

  mem_state_e              state_q, state_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic [c_block_size-1:0] beat_q, beat_d;
  logic                    op_rd_q, op_rd_d;
  logic                    busy_q, rd_done_q, wr_done_q;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    op_rd_d  = op_rd_q;
    accept_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A simultaneous read and write resolves to the read; the write is dropped.
        if (m_read_i || m_wr_i) begin
          accept_o = 1'b1;
          op_rd_d  = m_read_i;
          lat_d    = '0;
          beat_d   = '0;
          if (access_latency == 0) state_d = m_read_i ? StRead : StWrite;
          else                     state_d = StWait;
        end
      end
      StWait: begin
        if (lat_q == LatLast) begin
          lat_d   = '0;
          state_d = op_rd_q ? StRead : StWrite;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StRead, StWrite: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == BeatLast) state_d = (state_q == StRead) ? StDoneRd : StDoneWr;
      end
      StDoneRd, StDoneWr: state_d = StIdle;
      default:            state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_clk_i) begin
    if (m_reset_i) begin
      state_q   <= StIdle;
      lat_q     <= '0;
      beat_q    <= '0;
      op_rd_q   <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      beat_q    <= beat_d;
      op_rd_q   <= op_rd_d;
      busy_q    <= (state_d == StWait) || (state_d == StRead) || (state_d == StWrite);
      rd_done_q <= (state_d == StDoneRd);
      wr_done_q <= (state_d == StDoneWr);
    end
  end

  assign m_busywait_o   = busy_q;
  assign m_read_done_o  = rd_done_q;
  assign m_write_done_o = wr_done_q;
  assign beat_o         = beat_q;
  // Reset on the same edge must suppress the pending beat so aborted words stay untouched.
  assign wr_stb_o       = (state_q == StWrite) && !m_reset_i;
  assign cap_stb_o      = (state_q == StRead);
  assign last_beat_o    = (beat_q == BeatLast);

endmodule

// File: rtl/burst_memory.sv
// Multi-beat backing memory behind the cache: whole-block reads and masked block writes,
// one word per cycle after a fixed access latency, with one-cycle done pulses.
module burst_memory
  import cache_mem_pkg::*;
#(
  parameter int unsigned c_block_size   = 2,
  parameter int unsigned c_line_size    = 32,
  parameter int unsigned mem_depth_log2 = 11,
  parameter int unsigned access_latency = 2,
  parameter string       init_file      = ""
) (
  input  logic                                         m_clk_i,
  input  logic                                         m_reset_i,
  input  logic                                         m_read_i,
  input  logic                                         m_wr_i,
  input  logic [mem_depth_log2-c_block_size-1:0]       m_addr_i,
  input  logic [(2**c_block_size)*c_line_size-1:0]     m_wr_data_i,
  input  logic [2**c_block_size-1:0]                   m_wr_mask_i,
  output logic                                         m_busywait_o,
  output logic [(2**c_block_size)*c_line_size-1:0]     m_read_data_o,
  output logic                                         m_read_done_o,
  output logic                                         m_write_done_o
);

  localparam int unsigned Words = words_per_block(c_block_size);
  localparam int unsigned Width = c_line_size;
  localparam int unsigned AddrW = block_addr_width(mem_depth_log2, c_block_size);
  localparam int unsigned Depth = 2 ** mem_depth_log2;

  logic [AddrW-1:0]         addr_q;
  logic [Words*Width-1:0]   wr_data_q;
  logic [Words-1:0]         mask_q;
  logic [Words*Width-1:0]   buf_q, buf_d;
  logic [Words*Width-1:0]   read_data_q;
  logic [Width-1:0]         mem_q [Depth];
  logic [Width-1:0]         rd_word;
  logic [mem_depth_log2-1:0] word_addr;
  logic [c_block_size-1:0]  beat;
  logic                     accept, wr_stb, cap_stb, last_beat;

  mem_burst_ctrl #(
    .c_block_size   (c_block_size),
    .access_latency (access_latency)
  ) u_ctrl (
    .m_clk_i        (m_clk_i),
    .m_reset_i      (m_reset_i),
    .m_read_i       (m_read_i),
    .m_wr_i         (m_wr_i),
    .m_busywait_o   (m_busywait_o),
    .m_read_done_o  (m_read_done_o),
    .m_write_done_o (m_write_done_o),
    .accept_o       (accept),
    .beat_o         (beat),
    .wr_stb_o       (wr_stb),
    .cap_stb_o      (cap_stb),
    .last_beat_o    (last_beat)
  );

  // Request fields are frozen at acceptance so the requester may move on immediately.
  always_ff @(posedge m_clk_i) begin
    if (accept) begin
      addr_q    <= m_addr_i;
      wr_data_q <= m_wr_data_i;
      mask_q    <= m_wr_mask_i;
    end
  end

  assign word_addr = {addr_q, beat};
  assign rd_word   = mem_q[word_addr];

  always_ff @(posedge m_clk_i) begin
    if (wr_stb && mask_q[beat]) mem_q[word_addr] <= wr_data_q[beat*Width +: Width];
  end

  always_comb begin
    buf_d = buf_q;
    buf_d[beat*Width +: Width] = rd_word;
  end

  // The output block only moves when the final beat lands, never mid-burst.
  always_ff @(posedge m_clk_i) begin
    if (m_reset_i) begin
      buf_q       <= '0;
      read_data_q <= '0;
    end else if (cap_stb) begin
      buf_q <= buf_d;
      if (last_beat) read_data_q <= buf_d;
    end
  end

  assign m_read_data_o = read_data_q;

endmodule

// File: tb/tb_burst_memory.sv
// Self-checking bench for burst_memory: default build (latency 2, 4 words) and a
// zero-latency 8-word build, driven by a vector table plus hand-written corner sequences.
module tb_burst_memory;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default build: 4 x 32-bit words per block, latency 2.
  logic         a_rd, a_wr, a_busy, a_rdone, a_wdone;
  logic [8:0]   a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic [3:0]   a_mask;

  // Wide build: 8 x 32-bit words per block, latency 0.
  logic         b_rd, b_wr, b_busy, b_rdone, b_wdone;
  logic [7:0]   b_addr;
  logic [255:0] b_wdata, b_rdata;
  logic [7:0]   b_mask;

  burst_memory dut (
    .m_clk_i        (clk),
    .m_reset_i      (rst),
    .m_read_i       (a_rd),
    .m_wr_i         (a_wr),
    .m_addr_i       (a_addr),
    .m_wr_data_i    (a_wdata),
    .m_wr_mask_i    (a_mask),
    .m_busywait_o   (a_busy),
    .m_read_data_o  (a_rdata),
    .m_read_done_o  (a_rdone),
    .m_write_done_o (a_wdone)
  );

  burst_memory #(
    .c_block_size   (3),
    .access_latency (0)
  ) dut8 (
    .m_clk_i        (clk),
    .m_reset_i      (rst),
    .m_read_i       (b_rd),
    .m_wr_i         (b_wr),
    .m_addr_i       (b_addr),
    .m_wr_data_i    (b_wdata),
    .m_wr_mask_i    (b_mask),
    .m_busywait_o   (b_busy),
    .m_read_data_o  (b_rdata),
    .m_read_done_o  (b_rdone),
    .m_write_done_o (b_wdone)
  );

  typedef struct {
    bit           rd;
    bit           wr;
    logic [8:0]   addr;
    logic [127:0] data;
    logic [3:0]   mask;
    logic [127:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] sb_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request on the default build; optionally pokes new requests while busy.
  task automatic run_a(input bit r, input bit w, input logic [8:0] a, input logic [127:0] d,
                       input logic [3:0] m, input logic [127:0] exp, input bit poke,
                       input string name);
    int           busy_n;
    bit           stable;
    logic [127:0] prev;
    busy_n = 0;
    stable = 1'b1;
    @(negedge clk);
    a_rd = r; a_wr = w; a_addr = a; a_wdata = d; a_mask = m;
    if (r) sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    // Inputs scrambled after acceptance must have no effect.
    a_rd = 1'b0; a_wr = 1'b0; a_addr = ~a; a_wdata = ~d; a_mask = ~m;
    prev = a_rdata;
    for (int c = 0; c < 40 && !(a_rdone || a_wdone); c++) begin
      if (a_busy) busy_n++;
      if (a_rdata !== prev) stable = 1'b0;
      if (poke) begin
        a_rd = (c >= 1 && c <= 3);
        a_wr = (c == 2);
      end
      @(negedge clk);
    end
    a_rd = 1'b0; a_wr = 1'b0;
    check({name, " busy cycles"}, 256'(busy_n), 256'd6);
    check({name, " done kind"}, {254'd0, a_rdone, a_wdone}, {254'd0, r, ~r});
    check({name, " busy in done"}, {255'd0, a_busy}, 256'd0);
    check({name, " rdata stable mid-burst"}, {255'd0, stable}, 256'd1);
    if (a_rdone) begin
      if (sb_q.size() == 0) check({name, " scoreboard underflow"}, 256'd1, 256'd0);
      else check({name, " read data"}, {128'd0, a_rdata}, {128'd0, sb_q.pop_front()});
    end
    @(negedge clk);
    check({name, " done one-cycle"}, {253'd0, a_rdone, a_wdone, a_busy}, 256'd0);
  endtask

  task automatic run_b(input bit r, input logic [7:0] a, input logic [255:0] d,
                       input string name);
    int busy_n;
    busy_n = 0;
    @(negedge clk);
    b_rd = r; b_wr = ~r; b_addr = a; b_wdata = d; b_mask = '1;
    @(posedge clk);
    @(negedge clk);
    b_rd = 1'b0; b_wr = 1'b0;
    for (int c = 0; c < 40 && !(b_rdone || b_wdone); c++) begin
      if (b_busy) busy_n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 256'(busy_n), 256'd8);
    check({name, " done kind"}, {254'd0, b_rdone, b_wdone}, {254'd0, r, ~r});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         v [11];
    logic [127:0] blk;
    logic [255:0] wide;
    int           dones;

    v[0]  = '{1'b0, 1'b1, 9'h010, {32'h44, 32'h33, 32'h22, 32'h11}, 4'hF, 128'd0};
    v[1]  = '{1'b1, 1'b0, 9'h010, 128'd0, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11}};
    v[2]  = '{1'b0, 1'b1, 9'h010, {32'hDD, 32'hCC, 32'hBB, 32'hAA}, 4'b0101, 128'd0};
    v[3]  = '{1'b1, 1'b0, 9'h010, 128'd0, 4'h0, {32'h44, 32'hCC, 32'h22, 32'hAA}};
    v[4]  = '{1'b0, 1'b1, 9'h005, {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D},
              4'hF, 128'd0};
    v[5]  = '{1'b1, 1'b0, 9'h005, 128'd0, 4'h0,
              {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D}};
    v[6]  = '{1'b1, 1'b1, 9'h010, {4{32'hFFFFFFFF}}, 4'hF, {32'h44, 32'hCC, 32'h22, 32'hAA}};
    v[7]  = '{1'b1, 1'b0, 9'h010, 128'd0, 4'h0, {32'h44, 32'hCC, 32'h22, 32'hAA}};
    v[8]  = '{1'b0, 1'b1, 9'h1FF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 128'd0};
    v[9]  = '{1'b0, 1'b1, 9'h1FF, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1010, 128'd0};
    v[10] = '{1'b1, 1'b0, 9'h1FF, 128'd0, 4'h0, {32'hB3, 32'hA2, 32'hB1, 32'hA0}};

    rst = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_mask = '0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset idle flags", {253'd0, a_busy, a_rdone, a_wdone}, 256'd0);
      check("reset idle rdata", {128'd0, a_rdata}, 256'd0);
    end
    check("reset wide rdata/busy", {b_rdata[254:0], b_busy}, 256'd0);

    for (int i = 0; i < 11; i++)
      run_a(v[i].rd, v[i].wr, v[i].addr, v[i].data, v[i].mask, v[i].exp, 1'b0,
            $sformatf("vec%0d", i));

    // Requests raised while busy must be ignored, not queued.
    blk = {32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F, 32'h5A5A5A5A};
    run_a(1'b0, 1'b1, 9'h030, blk, 4'hF, 128'd0, 1'b1, "poke write");
    @(negedge clk);
    check("poke no extra busy", {255'd0, a_busy}, 256'd0);
    run_a(1'b1, 1'b0, 9'h030, 128'd0, 4'h0, blk, 1'b0, "poke readback");

    // Reset lands on the edge that would write word 2 of block 0x20.
    run_a(1'b0, 1'b1, 9'h020, 128'd0, 4'hF, 128'd0, 1'b0, "prefill 0x20");
    @(negedge clk);
    a_wr = 1'b1; a_addr = 9'h020; a_wdata = {32'h4, 32'h3, 32'h2, 32'h1}; a_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    a_wr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort busy/dones", {253'd0, a_busy, a_rdone, a_wdone}, 256'd0);
    check("abort rdata cleared", {128'd0, a_rdata}, 256'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_rdone || a_wdone || a_busy) dones++;
    end
    check("abort stays quiet", 256'(dones), 256'd0);
    run_a(1'b1, 1'b0, 9'h020, 128'd0, 4'h0, {32'h0, 32'h0, 32'h2, 32'h1}, 1'b0, "abort readback");

    // Zero-latency, 8-word build.
    for (int i = 0; i < 8; i++) wide[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
    run_b(1'b0, 8'hA5, wide, "wide write");
    run_b(1'b1, 8'hA5, '0, "wide read");
    check("wide word7 position", {224'd0, b_rdata[255:224]}, 256'hC0DE0007);
    check("wide block", b_rdata, wide);

    check("scoreboard drained", 256'(sb_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
